// File: rtl/probe_register_packer.sv
// Latches a REG_WIDTH-bit probe image on a Start_In rising edge and streams it to the
// configuration FIFO as WORD_WIDTH-bit words. Define PROBE_PACKER_CRC_EN for a CRC-8 trailer word.
module probe_register_packer #(
    parameter int REG_WIDTH  = 1544,
    parameter int WORD_WIDTH = 8,
    parameter int MSB_FIRST  = 1,
    parameter int CNT_WIDTH  = 12
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  Start_In,
    input  logic [REG_WIDTH-1:0]  In_Reg_Data,
    input  logic                  In_Fifo_Full,
    output logic                  Out_Ex_Fifo_Wr_En,
    output logic [WORD_WIDTH-1:0] Out_Ex_Fifo_Din,
    output logic                  Out_Busy,
    output logic [CNT_WIDTH-1:0]  Out_Word_Cnt,
    output logic                  End_Flag
);

    localparam int NUM_WORDS = (REG_WIDTH + WORD_WIDTH - 1) / WORD_WIDTH;
    localparam int PAD       = NUM_WORDS * WORD_WIDTH - REG_WIDTH;
    localparam int SR_WIDTH  = NUM_WORDS * WORD_WIDTH;
`ifdef PROBE_PACKER_CRC_EN
    localparam int CRC_WORDS = 1;
`else
    localparam int CRC_WORDS = 0;
`endif
    localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(NUM_WORDS - 1);

`ifdef PROBE_PACKER_CRC_EN
    if (WORD_WIDTH != 8) begin : g_bad_crc_width
        $error("probe_register_packer: CRC-8 trailer needs WORD_WIDTH == 8");
    end
`endif
    if (NUM_WORDS + CRC_WORDS >= (1 << CNT_WIDTH)) begin : g_bad_cnt_width
        $error("probe_register_packer: CNT_WIDTH too small for the word count");
    end

`ifdef PROBE_PACKER_CRC_EN
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WRITE, S_CRC, S_DONE} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WRITE, S_DONE} state_t;
`endif

    state_t                state_q, state_d;
    logic                  start_dly_q;
    logic [SR_WIDTH-1:0]   sr_q, sr_d;
    logic [WORD_WIDTH-1:0] din_q, din_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  wr_en;
    logic                  start_edge;

    logic [SR_WIDTH-1:0]   img_pad;
    logic [SR_WIDTH-1:0]   sr_shift;
    logic [WORD_WIDTH-1:0] img_head;
    logic [WORD_WIDTH-1:0] next_head;

`ifdef PROBE_PACKER_CRC_EN
    logic [7:0] crc_q, crc_d;
    logic [7:0] crc_next;

    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int b = 0; b < 8; b++) begin
            c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction

    assign crc_next = crc8_step(crc_q, 8'(din_q));
`endif

    assign start_edge = Start_In & ~start_dly_q;

    // Padding always sits at the tail of the stream, so its side depends on the shift direction.
    if (MSB_FIRST != 0) begin : g_msb_first
        assign img_pad   = SR_WIDTH'(In_Reg_Data) << PAD;
        assign sr_shift  = sr_q << WORD_WIDTH;
        assign img_head  = img_pad[SR_WIDTH-1 -: WORD_WIDTH];
        assign next_head = sr_shift[SR_WIDTH-1 -: WORD_WIDTH];
    end else begin : g_lsb_first
        assign img_pad   = SR_WIDTH'(In_Reg_Data);
        assign sr_shift  = sr_q >> WORD_WIDTH;
        assign img_head  = img_pad[WORD_WIDTH-1:0];
        assign next_head = sr_shift[WORD_WIDTH-1:0];
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q     <= S_IDLE;
            start_dly_q <= 1'b0;
            sr_q        <= '0;
            din_q       <= '0;
            cnt_q       <= '0;
`ifdef PROBE_PACKER_CRC_EN
            crc_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            start_dly_q <= Start_In;
            sr_q        <= sr_d;
            din_q       <= din_d;
            cnt_q       <= cnt_d;
`ifdef PROBE_PACKER_CRC_EN
            crc_q       <= crc_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        din_d   = din_q;
        cnt_d   = cnt_q;
        wr_en   = 1'b0;
`ifdef PROBE_PACKER_CRC_EN
        crc_d   = crc_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start_edge) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                sr_d    = img_pad;
                din_d   = img_head;
                cnt_d   = '0;
`ifdef PROBE_PACKER_CRC_EN
                crc_d   = '0;
`endif
                state_d = S_WRITE;
            end
            S_WRITE: begin
                // Din is pre-registered, so the following word is staged on every accepted write.
                if (!In_Fifo_Full) begin
                    wr_en = 1'b1;
                    sr_d  = sr_shift;
                    din_d = next_head;
                    cnt_d = cnt_q + CNT_WIDTH'(1);
`ifdef PROBE_PACKER_CRC_EN
                    crc_d = crc_next;
                    if (cnt_q == LAST_IDX) begin
                        din_d   = WORD_WIDTH'(crc_next);
                        state_d = S_CRC;
                    end
`else
                    if (cnt_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end
`endif
                end
            end
`ifdef PROBE_PACKER_CRC_EN
            S_CRC: begin
                if (!In_Fifo_Full) begin
                    wr_en   = 1'b1;
                    din_d   = '0;
                    cnt_d   = cnt_q + CNT_WIDTH'(1);
                    state_d = S_DONE;
                end
            end
`endif
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign Out_Ex_Fifo_Wr_En = wr_en;
    assign Out_Ex_Fifo_Din   = din_q;
    assign Out_Busy          = (state_q != S_IDLE);
    assign Out_Word_Cnt      = cnt_q;
    assign End_Flag          = (state_q == S_DONE);

endmodule

// File: tb/tb_probe_register_packer.sv
// Directed bench for probe_register_packer: default 1544-bit image plus small 20/16/8-bit variants.
module tb_probe_register_packer;

`ifdef PROBE_PACKER_CRC_EN
    localparam int CRC_ON = 1;
`else
    localparam int CRC_ON = 0;
`endif
    localparam int NW_A = 193 + CRC_ON;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          start_a, full_a;
    logic [1543:0] data_a;
    logic          wr_a, busy_a, end_a;
    logic [7:0]    din_a;
    logic [11:0]   cnt_a;

    logic          start_s [3];
    logic          full_s  [3];
    logic          wr_s    [3];
    logic          busy_s  [3];
    logic          end_s   [3];
    logic [7:0]    din_s   [3];
    logic [11:0]   cnt_s   [3];
    logic [19:0]   data_b;
    logic [15:0]   data_c;
    logic [7:0]    data_d;

    logic [7:0]    exp_s [6];
    logic [7:0]    crc_a_exp;
    int            checks   = 0;
    int            failures = 0;

    probe_register_packer dut_a (
        .Clk(clk), .Rst(rst), .Start_In(start_a), .In_Reg_Data(data_a), .In_Fifo_Full(full_a),
        .Out_Ex_Fifo_Wr_En(wr_a), .Out_Ex_Fifo_Din(din_a), .Out_Busy(busy_a),
        .Out_Word_Cnt(cnt_a), .End_Flag(end_a)
    );

    probe_register_packer #(.REG_WIDTH(20)) dut_b (
        .Clk(clk), .Rst(rst), .Start_In(start_s[0]), .In_Reg_Data(data_b), .In_Fifo_Full(full_s[0]),
        .Out_Ex_Fifo_Wr_En(wr_s[0]), .Out_Ex_Fifo_Din(din_s[0]), .Out_Busy(busy_s[0]),
        .Out_Word_Cnt(cnt_s[0]), .End_Flag(end_s[0])
    );

    probe_register_packer #(.REG_WIDTH(16), .MSB_FIRST(0)) dut_c (
        .Clk(clk), .Rst(rst), .Start_In(start_s[1]), .In_Reg_Data(data_c), .In_Fifo_Full(full_s[1]),
        .Out_Ex_Fifo_Wr_En(wr_s[1]), .Out_Ex_Fifo_Din(din_s[1]), .Out_Busy(busy_s[1]),
        .Out_Word_Cnt(cnt_s[1]), .End_Flag(end_s[1])
    );

`ifdef PROBE_PACKER_CRC_EN
    probe_register_packer #(.REG_WIDTH(8)) dut_d (
        .Clk(clk), .Rst(rst), .Start_In(start_s[2]), .In_Reg_Data(data_d), .In_Fifo_Full(full_s[2]),
        .Out_Ex_Fifo_Wr_En(wr_s[2]), .Out_Ex_Fifo_Din(din_s[2]), .Out_Busy(busy_s[2]),
        .Out_Word_Cnt(cnt_s[2]), .End_Flag(end_s[2])
    );
`else
    assign wr_s[2]   = 1'b0;
    assign busy_s[2] = 1'b0;
    assign end_s[2]  = 1'b0;
    assign din_s[2]  = '0;
    assign cnt_s[2]  = '0;
`endif

    function automatic logic [7:0] crc8(input logic [7:0] c_in, input logic [7:0] d);
        logic [7:0] c;
        c = c_in ^ d;
        for (int b = 0; b < 8; b++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        return c;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One transfer on the 1544-bit instance; optional Full pattern, mid-stream reset, held Start.
    task automatic run_a(input int stall, input int rst_after, input int held);
        int n, ends, end_cyc, first_cyc, viol, cnt_err, retrig, rst_cyc;
        logic [7:0] e;
        n = 0; ends = 0; end_cyc = -1; first_cyc = -1;
        viol = 0; cnt_err = 0; retrig = 0; rst_cyc = -1;
        start_a = 1'b1;
        full_a  = 1'b0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            @(negedge clk);
            if (cyc >= 2 && rst_cyc < 0 && cnt_a !== 12'(n)) cnt_err++;
            if (wr_a) begin
                if (full_a) viol++;
                if (first_cyc < 0) first_cyc = cyc;
                e = (n < 193) ? 8'(192 - n) : crc_a_exp;
                check($sformatf("a_word%0d", n), din_a, e);
                n++;
            end
            if (end_a) begin
                ends++;
                end_cyc = cyc;
            end
            if (ends > 0 && cyc > end_cyc && busy_a) retrig++;
            if (rst_after > 0 && rst_cyc < 0 && n == rst_after) begin
                rst = 1'b1;
                rst_cyc = cyc;
            end
            @(posedge clk);
            #1;
            if (rst === 1'b1) begin
                rst = 1'b0;
                check("midrst_wr_en", wr_a, 0);
                check("midrst_busy", busy_a, 0);
                check("midrst_cnt", cnt_a, 0);
            end
            start_a = held ? (cyc + 1 != 20) : 1'b0;
            full_a  = (stall != 0) && ((cyc + 1 >= 10 && cyc + 1 <= 19) || ((cyc + 1) % 7 == 0));
            if (stall != 0 && cyc + 1 == 5) data_a = ~data_a;
            if (ends > 0 && cyc >= end_cyc + 12) break;
            if (rst_cyc >= 0 && cyc >= rst_cyc + 20) break;
        end
        if (stall != 0) data_a = ~data_a;
        full_a = 1'b0;
        if (rst_after > 0) begin
            check("midrst_writes", n, rst_after);
            check("midrst_end_flag", ends, 0);
        end else begin
            check("a_writes", n, NW_A);
            check("a_end_count", ends, 1);
            check("a_final_cnt", cnt_a, NW_A);
            check("a_retrigger", retrig, 0);
            if (stall == 0) begin
                check("a_first_wr_cycle", first_cyc, 2);
                check("a_end_cycle", end_cyc, NW_A + 2);
            end
        end
        check("a_wr_while_full", viol, 0);
        check("a_cnt_track", cnt_err, 0);
    endtask

    // One start pulse on small instance k; words compared against exp_s.
    task automatic run_small(input int k, input int nexp);
        int n, ends, end_cyc;
        n = 0; ends = 0; end_cyc = -1;
        start_s[k] = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (wr_s[k]) begin
                if (n < 6) check($sformatf("s%0d_word%0d", k, n), din_s[k], exp_s[n]);
                n++;
            end
            if (end_s[k]) begin
                ends++;
                end_cyc = cyc;
            end
            @(posedge clk);
            #1;
            start_s[k] = 1'b0;
            if (ends > 0 && cyc >= end_cyc + 2) break;
        end
        check($sformatf("s%0d_writes", k), n, nexp);
        check($sformatf("s%0d_end_count", k), ends, 1);
        check($sformatf("s%0d_end_cycle", k), end_cyc, nexp + 2);
        check($sformatf("s%0d_final_cnt", k), cnt_s[k], nexp);
    endtask

    initial begin
        rst = 1'b1;
        start_a = 1'b0;
        full_a  = 1'b0;
        for (int i = 0; i < 193; i++) data_a[8*i +: 8] = 8'(i);
        for (int k = 0; k < 3; k++) begin
            start_s[k] = 1'b0;
            full_s[k]  = 1'b0;
        end
        data_b = 20'hABCDE;
        data_c = 16'hA55A;
        data_d = 8'h01;
        crc_a_exp = 8'h00;
        for (int i = 0; i < 193; i++) crc_a_exp = crc8(crc_a_exp, 8'(192 - i));
        for (int i = 0; i < 6; i++) exp_s[i] = 8'h00;

        // Reset state
        idle(3);
        check("reset_wr_en", wr_a, 0);
        check("reset_din", din_a, 0);
        check("reset_busy", busy_a, 0);
        check("reset_cnt", cnt_a, 0);
        check("reset_end_flag", end_a, 0);
        rst = 1'b0;
        idle(1);
        check("post_reset_busy", busy_a, 0);

        // Start edge coinciding with reset: reset wins
        rst = 1'b1;
        start_a = 1'b1;
        idle(1);
        check("rst_vs_start_busy", busy_a, 0);
        rst = 1'b0;
        start_a = 1'b0;
        idle(1);
        check("rst_vs_start_idle", busy_a, 0);
        idle(2);

        // Test 1: no backpressure
        run_a(0, 0, 0);
        idle(3);
        // Test 2: Full on cycles 10-19 and every 7th cycle; image changed after LOAD
        run_a(1, 0, 0);
        idle(3);
        // Test 5: reset after 50 writes, then a full stream with Start held and re-pulsed while busy
        run_a(0, 50, 0);
        idle(3);
        run_a(0, 0, 1);
        start_a = 1'b0;
        idle(3);

        // Test 3: 20-bit image, MSB first, 4 pad zeros
        exp_s[0] = 8'hAB; exp_s[1] = 8'hCD; exp_s[2] = 8'hE0;
        exp_s[3] = crc8(crc8(crc8(8'h00, 8'hAB), 8'hCD), 8'hE0);
        run_small(0, 3 + CRC_ON);
        idle(2);
        // Test 4: 16-bit image, LSB first
        for (int i = 0; i < 6; i++) exp_s[i] = 8'h00;
        exp_s[0] = 8'h5A; exp_s[1] = 8'hA5;
        exp_s[2] = crc8(crc8(8'h00, 8'h5A), 8'hA5);
        run_small(1, 2 + CRC_ON);
        idle(2);

`ifdef PROBE_PACKER_CRC_EN
        // Test 6: CRC trailer on an 8-bit image
        for (int i = 0; i < 6; i++) exp_s[i] = 8'h00;
        data_d = 8'h01;
        exp_s[0] = 8'h01; exp_s[1] = 8'h07;
        run_small(2, 2);
        idle(2);
        data_d = 8'h00;
        exp_s[0] = 8'h00; exp_s[1] = 8'h00;
        run_small(2, 2);
        idle(2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
